branch_redirect: RTL and testbench
==================================

# branch_redirect

Execute-stage redirect controller directly downstream of the branch-condition logic. It consumes the resolved `brchcnd` decision and the computed target for an executing control-flow instruction. For a taken branch or jump, it drives a registered PC redirect to fetch with a valid/ready handshake and squashes the wrong-path instructions in IF and ID. It back-pressures execute until the redirect has been consumed.

## Interface
- `PC_W`, default 16: PC / target width.
- `CNT_W`, default 16: width of the taken-redirect counter.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ex_valid`, in, 1: execute holds a valid control-flow instruction this cycle.
- `brchcnd`, in, 1: branch-condition result; 1 = taken (includes JUMP).
- `ex_target`, in, PC_W: computed branch/jump target.
- `fetch_ready`, in, 1: fetch accepts the redirect this cycle.
- `ex_ready`, out, 1: block can accept a decision; execute stalls when 0.
- `redirect_valid`, out, 1: `redirect_pc` is valid.
- `redirect_pc`, out, PC_W: redirect address, LSB forced to 0.
- `flush_id`, out, 1: kill the instruction in ID.
- `flush_if`, out, 1: kill the instruction in IF.
- `misalign_err`, out, 1: sticky; set when an accepted target had LSB = 1.
- `taken_cnt`, out, CNT_W: count of accepted redirects (see Configuration).

## Operation
- FSM states:
  - IDLE (reset state).
  - REDIRECT.
  - SQUASH.
- `ex_ready` = (state == IDLE). It is a decode of the registered state and has no combinational path from the inputs.
- Accept condition: `ex_valid & ex_ready`.
  - Accepted with `brchcnd` = 1:
    - capture `{ex_target[PC_W-1:1], 1'b0}` into `redirect_pc`;
    - set `misalign_err` if `ex_target[0]`;
    - go to REDIRECT.
  - Accepted with `brchcnd` = 0: no state change and no outputs (fall-through).
- In REDIRECT:
  - `redirect_valid` = 1 and `flush_if` = 1.
  - `flush_id` = 1 only in the first REDIRECT cycle.
  - `redirect_pc` is held stable until handshake completion.
  - If `fetch_ready` = 1: handshake completes and the next state is SQUASH.
  - Otherwise the block stays in REDIRECT with all values held.
- In SQUASH:
  - `redirect_valid` = 0 and `flush_if` = 1, killing the fetch issued in the handshake cycle.
  - Next state is IDLE unconditionally.
- `ex_valid` and `brchcnd` are ignored outside IDLE. Upstream must hold the next instruction while `ex_ready` = 0.
- `fetch_ready` is ignored outside REDIRECT.
- `misalign_err` clears only on reset.
- Reset values of all outputs:
  - `redirect_valid` 0, `redirect_pc` 0, `flush_if` 0, `flush_id` 0;
  - `misalign_err` 0, `taken_cnt` 0;
  - `ex_ready` 1 (state IDLE).
- Reset asserted mid-operation (REDIRECT or SQUASH) returns to IDLE immediately, independent of `clk`, and the pending redirect is dropped.

## Timing
- Cycle N: taken decision accepted.
- Cycle N+1: REDIRECT, with `redirect_valid` = `flush_if` = `flush_id` = 1 and `ex_ready` = 0.
- With `fetch_ready` = 1 at N+1:
  - N+2: SQUASH (`flush_if` = 1, `redirect_valid` = 0);
  - N+3: IDLE with `ex_ready` = 1.
- Minimum redirect penalty is 3 cycles. Each cycle of `fetch_ready` = 0 in REDIRECT adds one cycle.
- A new decision presented at N+3 is accepted at N+3, so back-to-back taken branches are spaced 3 cycles apart.
- All outputs except `ex_ready` are flop outputs. `ex_ready` is a pure state decode.

## Configuration
- `BRANCH_CNT_EN` defined:
  - `taken_cnt` increments by 1 on every accepted taken decision, at the same edge that enters REDIRECT;
  - it wraps from 2^CNT_W−1 to 0.
- `BRANCH_CNT_EN` undefined: the counter register is not built and `taken_cnt` is tied to 0.

## Test plan
- Reset, then accept not-taken (`ex_valid`=1, `brchcnd`=0, `ex_target`=0x0040):
  - no redirect and no flush;
  - `ex_ready` stays 1;
  - `taken_cnt`=0.
- Taken with target 0x1234 and `fetch_ready`=1 always:
  - N+1: `redirect_valid`=1, `redirect_pc`=0x1234, `flush_id`=1;
  - N+2: `flush_if`=1 only;
  - N+3: `ex_ready`=1;
  - `taken_cnt`=1 (with `BRANCH_CNT_EN`).
- Taken with target 0x0101 and `fetch_ready` held 0 for 4 cycles:
  - `redirect_pc`=0x0100 held for 5 cycles;
  - `flush_id` high in the first cycle only;
  - `misalign_err`=1 and stays 1.
- Changing `ex_target` and `brchcnd` during REDIRECT/SQUASH: `redirect_pc` unchanged and no extra redirect.
- `rst_n` dropped mid-REDIRECT: outputs return to reset values asynchronously (before the next edge); after release, IDLE with `ex_ready`=1.
- `CNT_W`=4 with `BRANCH_CNT_EN`: 17 taken branches → `taken_cnt`=1 (wrap verified). Without the macro, `taken_cnt`=0 throughout.

Source files
------------

// File: rtl/branch_redirect.sv
// branch_redirect: execute-stage PC redirect controller with IF/ID squash and execute back-pressure.
// Define BRANCH_CNT_EN to build the wrapping taken-redirect counter; otherwise taken_cnt is tied to 0.
module branch_redirect #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             brchcnd,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             fetch_ready,
  output logic             ex_ready,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_id,
  output logic             flush_if,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_cnt
);
  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
  state_t state, state_nxt;
  logic   accept;
  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready & brchcnd;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? REDIRECT :
                (state == REDIRECT && fetch_ready) ? SQUASH :
                (state == SQUASH) ? IDLE : state;
  end
  // Flag outputs are registered copies of the decoded next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      redirect_pc    <= '0;
      misalign_err   <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= (state_nxt == REDIRECT);
      flush_if       <= (state_nxt != IDLE);
      flush_id       <= accept;
      redirect_pc    <= accept ? {ex_target[PC_W-1:1], 1'b0} : redirect_pc;
      misalign_err   <= misalign_err | (accept & ex_target[0]);
    end
  end
`ifdef BRANCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (accept) cnt <= cnt + CNT_W'(1);
  end
  assign taken_cnt = cnt;
`else
  assign taken_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: randomized plus directed self-checking bench against a behavioural redirect model.
module tb_branch_redirect;
  localparam int PC_W = 16;
  localparam int CNT_W = 4;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, brchcnd = 0, fetch_ready = 0;
  logic [PC_W-1:0] ex_target = '0;
  logic ex_ready, redirect_valid, flush_id, flush_if, misalign_err;
  logic [PC_W-1:0] redirect_pc;
  logic [CNT_W-1:0] taken_cnt;
  int total = 0, passed = 0;

  branch_redirect #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .brchcnd(brchcnd),
    .ex_target(ex_target), .fetch_ready(fetch_ready), .ex_ready(ex_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_id(flush_id), .flush_if(flush_if), .misalign_err(misalign_err),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Model: an outstanding redirect (with its age), then one squash cycle.
  bit m_pend = 0, m_sq = 0, m_mis = 0;
  int m_age = 0, m_cnt = 0;
  logic [PC_W-1:0] m_pc = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_sq = 0; m_mis = 0; m_age = 0; m_cnt = 0; m_pc = '0;
    end else if (!m_pend && !m_sq && ex_valid && brchcnd) begin
      m_pend = 1; m_age = 0; m_pc = ex_target & ~PC_W'(1);
      m_mis = m_mis | ex_target[0]; m_cnt++;
    end else if (m_pend) begin
      if (fetch_ready) begin m_pend = 0; m_sq = 1; end
      else m_age++;
    end else if (m_sq) m_sq = 0;
  end

  function automatic int exp_cnt();
`ifdef BRANCH_CNT_EN
    return m_cnt % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("ex_ready", 32'(ex_ready), 32'(!m_pend && !m_sq));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_pend));
    chk("flush_if", 32'(flush_if), 32'(m_pend || m_sq));
    chk("flush_id", 32'(flush_id), 32'(m_pend && m_age == 0));
    chk("redirect_pc", 32'(redirect_pc), 32'(m_pc));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("taken_cnt", 32'(taken_cnt), 32'(exp_cnt()));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic v, input logic b, input logic [PC_W-1:0] t, input logic fr);
    ex_valid = v; brchcnd = b; ex_target = t; fetch_ready = fr;
  endtask

  initial begin
    #12;
    chk("reset ex_ready", 32'(ex_ready), 1);
    chk("reset redirect_valid", 32'(redirect_valid), 0);
    chk("reset redirect_pc", 32'(redirect_pc), 0);
    chk("reset taken_cnt", 32'(taken_cnt), 0);
    chk("reset misalign", 32'(misalign_err), 0);
    rst_n = 1;
    step();
    drive(1, 0, 16'h0040, 1);
    step();
    drive(0, 0, 0, 1);
    chk("nt redirect_valid", 32'(redirect_valid), 0);
    chk("nt flush_if", 32'(flush_if), 0);
    chk("nt ex_ready", 32'(ex_ready), 1);
    chk("nt taken_cnt", 32'(taken_cnt), 0);
    drive(1, 1, 16'h1234, 1);
    step();
    drive(0, 0, 0, 1);
    chk("t1 redirect_valid", 32'(redirect_valid), 1);
    chk("t1 redirect_pc", 32'(redirect_pc), 32'h1234);
    chk("t1 flush_id", 32'(flush_id), 1);
    chk("t1 ex_ready", 32'(ex_ready), 0);
    step();
    chk("t2 flush_if", 32'(flush_if), 1);
    chk("t2 redirect_valid", 32'(redirect_valid), 0);
    chk("t2 flush_id", 32'(flush_id), 0);
    step();
    chk("t3 ex_ready", 32'(ex_ready), 1);
`ifdef BRANCH_CNT_EN
    chk("t3 taken_cnt", 32'(taken_cnt), 1);
`else
    chk("t3 taken_cnt", 32'(taken_cnt), 0);
`endif
    drive(1, 1, 16'h0101, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold redirect_pc", 32'(redirect_pc), 32'h0100);
      chk("hold redirect_valid", 32'(redirect_valid), 1);
      chk("hold flush_id", 32'(flush_id), 32'(i == 0));
      chk("hold misalign", 32'(misalign_err), 1);
      drive(1, 1'($urandom), 16'($urandom), i == 4);
      step();
    end
    chk("sq redirect_pc", 32'(redirect_pc), 32'h0100);
    chk("sq redirect_valid", 32'(redirect_valid), 0);
    step();
    drive(0, 0, 0, 0);
    chk("after ex_ready", 32'(ex_ready), 1);
    chk("after misalign", 32'(misalign_err), 1);
    drive(1, 1, 16'h2222, 0);
    step();
    drive(0, 0, 0, 0);
    chk("pre-rst redirect_valid", 32'(redirect_valid), 1);
    #1 rst_n = 0;
    #1;
    chk("arst redirect_valid", 32'(redirect_valid), 0);
    chk("arst flush_if", 32'(flush_if), 0);
    chk("arst redirect_pc", 32'(redirect_pc), 0);
    chk("arst misalign", 32'(misalign_err), 0);
    chk("arst ex_ready", 32'(ex_ready), 1);
    @(negedge clk); #1 rst_n = 1;
    step();
    chk("post-rst ex_ready", 32'(ex_ready), 1);
    chk("post-rst redirect_valid", 32'(redirect_valid), 0);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 1'($urandom_range(0, 2) != 0));
      step();
    end
    drive(0, 0, 0, 1);
    step(); step(); step();
    @(negedge clk); #1 rst_n = 0;
    @(negedge clk); #1 rst_n = 1;
    step();
    drive(1, 1, 16'h0a0a, 1);
    for (int i = 0; i < 51; i++) step();
    drive(0, 0, 0, 1);
    step(); step();
`ifdef BRANCH_CNT_EN
    chk("wrap taken_cnt", 32'(taken_cnt), 1);
`else
    chk("wrap taken_cnt", 32'(taken_cnt), 0);
`endif
    chk("wrap ex_ready", 32'(ex_ready), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
